// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: default word width, FSM state
// encodings and the bytes-per-word helper.
package program_loader_pkg;

    localparam int LD_WORD_SIZE = 16;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA,
        LD_WRITE,
        LD_CSUM,
        LD_DONE
    } ld_state_t;

    function automatic int bytes_per_word(input int word_size);
        return word_size / 8;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = the loader, slave = the stream source / memory side.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int WORD_SIZE = LD_WORD_SIZE
);
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_data;

    modport master (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_data
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/program_loader_byte_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB first and flags the
// shift that completes a word.
module byte_packer
    import program_loader_pkg::*;
#(
    parameter int WORD_SIZE = LD_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 shift,
    input  logic [7:0]           byte_in,
    output logic [WORD_SIZE-1:0] word,
    output logic                 word_full
);
    localparam int BYTES_PER_WORD = bytes_per_word(WORD_SIZE);
    localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);

    logic [CW-1:0] cnt;

    // High on the shift that delivers the final byte of the current word.
    assign word_full = shift && (cnt == LAST);

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (clear) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift) begin
            word <= (word << 8) | WORD_SIZE'(byte_in);
            cnt  <= word_full ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Instruction-memory loader: receives a length-prefixed byte stream, writes
// whole words from BASE_ADDR upward and stalls the CPU until the load is done.
// Optional trailing XOR checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                   WORD_SIZE = LD_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    program_loader_if.master     bus,
    output logic                 cpu_hold,
    output logic                 done,
    output logic [WORD_SIZE-1:0] words_loaded
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    output logic                 csum_err
`endif
);
    localparam int LW = (WORD_SIZE > 16) ? WORD_SIZE : 16;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam ld_state_t END_STATE = LD_CSUM;
`else
    localparam ld_state_t END_STATE = LD_DONE;
`endif

    ld_state_t            state, state_next;
    logic [15:0]          len;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] mem_data_q;
    logic [WORD_SIZE-1:0] word;
    logic                 word_full;
    logic                 transfer;
    logic                 start_accept;
    logic                 last_word;

    assign transfer     = bus.in_valid && bus.in_ready;
    assign start_accept = start && (state == LD_IDLE || state == LD_DONE);
    assign last_word    = (LW'(words_loaded) + LW'(1)) == LW'(len);

    byte_packer #(.WORD_SIZE(WORD_SIZE)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_accept),
        .shift     (state == LD_DATA && transfer),
        .byte_in   (bus.in_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LD_IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        bus.mem_we   = 1'b0;
        unique case (state)
            LD_IDLE, LD_DONE: begin
                if (start) state_next = LD_LEN_HI;
            end
            LD_LEN_HI: begin
                bus.in_ready = 1'b1;
                if (transfer) state_next = LD_LEN_LO;
            end
            LD_LEN_LO: begin
                bus.in_ready = 1'b1;
                if (transfer)
                    state_next = ({len[15:8], bus.in_data} == 16'd0) ? END_STATE : LD_DATA;
            end
            LD_DATA: begin
                bus.in_ready = 1'b1;
                if (word_full) state_next = LD_WRITE;
            end
            LD_WRITE: begin
                bus.mem_we = 1'b1;
                state_next = last_word ? END_STATE : LD_DATA;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            LD_CSUM: begin
                bus.in_ready = 1'b1;
                if (transfer) state_next = LD_DONE;
            end
`endif
            default: state_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len          <= '0;
            addr         <= '0;
            words_loaded <= '0;
            mem_data_q   <= '0;
        end else begin
            if (start_accept) begin
                addr         <= BASE_ADDR;
                words_loaded <= '0;
            end
            if (state == LD_LEN_HI && transfer) len[15:8] <= bus.in_data;
            if (state == LD_LEN_LO && transfer) len[7:0]  <= bus.in_data;
            if (state == LD_WRITE) begin
                addr         <= addr + WORD_SIZE'(1);
                words_loaded <= words_loaded + WORD_SIZE'(1);
                mem_data_q   <= word;
            end
        end
    end

    // Write data comes straight from the packer during WRITE and is held after.
    assign bus.mem_addr = addr;
    assign bus.mem_data = bus.mem_we ? word : mem_data_q;
    assign done         = (state == LD_DONE);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum     <= '0;
            csum_err <= 1'b0;
        end else if (start_accept) begin
            csum     <= '0;
            csum_err <= 1'b0;
        end else if (transfer) begin
            if (state == LD_CSUM) csum_err <= (bus.in_data != csum);
            else                  csum     <= csum ^ bus.in_data;
        end
    end

    // A bad image keeps the CPU stalled even though the load has finished.
    assign cpu_hold = !(state == LD_DONE && !csum_err);
`else
    assign cpu_hold = !(state == LD_DONE);
`endif

endmodule
